// File: rtl/cpu_pkg.sv
// Shared CPU types: EX->WB pipeline entry, retire queue entry, opcode constants.
package cpu_pkg;

    localparam int NREGS_C = 16;

    // 209-bit EX->WB pipeline register payload (MSB first as listed).
    typedef struct packed {
        logic [63:0] pc_contents;
        logic [63:0] alu_result;
        logic [63:0] alu_ext_result;
        logic [7:0]  ctl_opcode;
        logic [3:0]  ctl_regByte;
        logic [3:0]  ctl_rmByte;
        logic        sim_end;
    } EX_WB;

    // Queue slot: the entry plus its dependency code.
    typedef struct packed {
        EX_WB       ex;
        logic [1:0] dep;
    } rq_entry_t;

    // Scoreboard mask, element 0 is the MSB.
    typedef logic [0:NREGS_C-1] sbmask_t;

    typedef enum logic [1:0] {S_RUN, S_EXT, S_HALT} state_t;

    localparam logic [7:0] OP_IMUL    = 8'd247;
    localparam logic [7:0] OP_PUSH_LO = 8'd80;
    localparam logic [7:0] OP_PUSH_HI = 8'd87;
    localparam logic [7:0] OP_GRP1_81 = 8'h81;
    localparam logic [7:0] OP_GRP1_83 = 8'h83;
    localparam logic [7:0] OP_JE      = 8'd116;
    localparam logic [7:0] OP_JNL     = 8'd125;

    localparam logic [3:0] REG_RAX = 4'd0;
    localparam logic [3:0] REG_RDX = 4'd2;
    localparam logic [3:0] REG_CMP = 4'd7;   // group-1 /7 encodes CMP

    function automatic logic is_jcc(input EX_WB e);
        return (e.ctl_opcode == OP_JE) || (e.ctl_opcode == OP_JNL);
    endfunction

    // PUSH, CMP and jumps produce no architectural register result.
    function automatic logic no_write(input EX_WB e);
        logic push_op, cmp_op;
        push_op = (e.ctl_opcode >= OP_PUSH_LO) && (e.ctl_opcode <= OP_PUSH_HI);
        cmp_op  = ((e.ctl_opcode == OP_GRP1_81) || (e.ctl_opcode == OP_GRP1_83)) &&
                  (e.ctl_regByte == REG_CMP);
        return push_op || cmp_op || is_jcc(e);
    endfunction

    // Scoreboard bits released when an entry finishes.
    function automatic sbmask_t rel_mask(input rq_entry_t q);
        sbmask_t m;
        m = '0;
        m[q.ex.ctl_rmByte] = 1'b1;
        if (q.dep == 2'd2) m[q.ex.ctl_regByte] = 1'b1;
        return m;
    endfunction

endpackage

// File: rtl/mod_retire_queue.sv
// Two-entry in-order retire FIFO with synchronous flush.
module mod_retire_queue
    import cpu_pkg::*;
(
    input  logic      clk,
    input  logic      reset,
    input  logic      push,
    input  logic      pop,
    input  logic      flush,
    input  rq_entry_t din,
    output rq_entry_t dout,
    output logic [1:0] count,
    output logic      full,
    output logic      empty
);
    rq_entry_t mem [2];
    logic      rd_ptr;
    logic      wr_ptr;
    logic      do_push;
    logic      do_pop;

    assign full    = (count == 2'd2);
    assign empty   = (count == 2'd0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Pointer/occupancy tracking; flush drops everything queued.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else if (flush) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) wr_ptr <= ~wr_ptr;
            if (do_pop)  rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

    // Payload storage needs no reset; occupancy gates its use.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/mod_retire.sv
// Retire stage: queues EX->WB entries, commits them to the register file,
// releases scoreboard bits and halts on sim_end.
module mod_retire
    import cpu_pkg::*;
#(
    parameter int NREGS = 16,
    parameter int XLEN  = 64,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wb_valid,
    output logic                       wb_ready,
    input  EX_WB                       exwb,
    input  logic [1:0]                 wb_dep,
    output logic [NREGS-1:0][XLEN-1:0] regfile,
    output logic [0:NREGS-1]           sb_clear,
    output logic                       retire_valid,
    output logic [63:0]                retired_pc,
    output logic                       sim_done
);
    state_t     state, state_nx;
    rq_entry_t  head;
    EX_WB       hx;
    logic       push, q_push, q_pop, q_flush, q_full, q_empty;
    logic [1:0] q_count, count_nx;
    logic       ready_nx;
    logic       wr_en, fin;
    logic [3:0] wr_idx;
    logic [XLEN-1:0] wr_data;
    sbmask_t    clr;

    assign hx      = head.ex;
    assign push    = wb_valid && wb_ready;
    assign q_push  = push && !q_full;
    assign q_pop   = fin;
    assign q_flush = (state == S_HALT);

    mod_retire_queue u_queue (
        .clk   (clk),
        .reset (reset),
        .push  (q_push),
        .pop   (q_pop),
        .flush (q_flush),
        .din   ('{ex: exwb, dep: wb_dep}),
        .dout  (head),
        .count (q_count),
        .full  (q_full),
        .empty (q_empty)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_RUN;
        else        state <= state_nx;
    end

    // Next state: IMUL takes an extra cycle, sim_end parks in HALT until reset.
    always_comb begin
        state_nx = state;
        case (state)
            S_RUN: if (!q_empty) begin
                if (hx.ctl_opcode == OP_IMUL) state_nx = S_EXT;
                else if (hx.sim_end)          state_nx = S_HALT;
            end
            S_EXT:   state_nx = hx.sim_end ? S_HALT : S_RUN;
            default: state_nx = S_HALT;
        endcase
    end

    // Per-cycle commit decision: write port, finish/pop, scoreboard release.
    always_comb begin
        wr_en   = 1'b0;
        wr_idx  = '0;
        wr_data = '0;
        fin     = 1'b0;
        clr     = '0;
        case (state)
            S_RUN: if (!q_empty) begin
                if (hx.ctl_opcode == OP_IMUL) begin
                    wr_en   = 1'b1;
                    wr_idx  = REG_RAX;
                    wr_data = hx.alu_result;
                end else begin
                    fin     = 1'b1;
                    wr_en   = !no_write(hx);
                    wr_idx  = hx.ctl_rmByte;
                    wr_data = hx.alu_result;
                    if (!is_jcc(hx)) clr = rel_mask(head);
                end
            end
            S_EXT: begin
                wr_en        = 1'b1;
                wr_idx       = REG_RDX;
                wr_data      = hx.alu_ext_result;
                fin          = 1'b1;
                clr          = rel_mask(head);
                clr[REG_RAX] = 1'b1;
                clr[REG_RDX] = 1'b1;
            end
            default: ;
        endcase
    end

    // Ready is registered from next-cycle occupancy so pops never reach it combinationally.
    always_comb begin
        count_nx = q_flush ? 2'd0 : q_count + {1'b0, q_push} - {1'b0, q_pop};
        ready_nx = (state_nx != S_HALT) && (count_nx < 2'(DEPTH));
    end

    // Registered architectural outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            regfile      <= '0;
            sb_clear     <= '0;
            retire_valid <= 1'b0;
            retired_pc   <= '0;
            sim_done     <= 1'b0;
            wb_ready     <= 1'b0;
        end else begin
            if (wr_en) regfile[wr_idx] <= wr_data;
            sb_clear     <= clr;
            retire_valid <= fin;
            if (fin) retired_pc <= hx.pc_contents;
            if (fin && hx.sim_end) sim_done <= 1'b1;
            wb_ready     <= ready_nx;
        end
    end

endmodule

// File: doc/mod_retire.md
# mod_retire

Retirement stage at the consuming end of the EX→WB pipeline register. Accepts completed EX_WB entries from the execute stage through a valid/ready handshake and buffers them in a 2-entry queue. Commits results to the 16×64 architectural register file through a single write port, including a second write cycle for the IMUL RDX:RAX pair. Releases scoreboard bits and halts the pipeline front on a sim_end entry.

## Interface
- NREGS, 16, architectural register count
- XLEN, 64, register width
- DEPTH, 2, retire queue entries (fixed at 2; other values unsupported)
- clk  in  1  core clock
- reset  in  1  asynchronous, active-low reset
- wb_valid  in  1  execute presents a completed entry
- wb_ready  out  1  retire can accept an entry this cycle
- exwb  in  EX_WB (209)  pc_contents, alu_result, alu_ext_result, ctl_opcode, ctl_regByte, ctl_rmByte, sim_end
- wb_dep  in  2  dependency code; 2 means ctl_regByte is also a destination to release
- regfile  out  NREGS×XLEN  architectural register file
- sb_clear  out  NREGS  one-cycle pulse mask of scoreboard bits to clear
- retire_valid  out  1  pulse: one entry fully retired this cycle
- retired_pc  out  64  pc_contents of the last retired entry
- sim_done  out  1  sticky: a sim_end entry has retired

## Operation
- Accept when wb_valid && wb_ready; entry plus wb_dep is pushed into the queue.
- wb_ready = (count < 2) && state != HALT. Computed from registered state only; no combinational path from the pop to ready.
- FSM states: RUN, EXT, HALT.
- RUN, queue non-empty: process the head entry.
  - Destination is ctl_rmByte.
  - No regfile write when ctl_opcode ∈ 80..87 (PUSH).
  - No regfile write when ctl_opcode ∈ {0x81, 0x83} and ctl_regByte == 7 (CMP).
  - Otherwise write regfile[rmByte] = alu_result.
  - Opcode 247 (IMUL): write regfile[0] = alu_result, then go to EXT; the head is not popped.
  - Every other opcode: pop the head, pulse retire_valid, update retired_pc.
- EXT: write regfile[2] = alu_ext_result, pop, pulse retire_valid, return to RUN.
- sb_clear on the final retire cycle of an entry:
  - bit rmByte set;
  - bit regByte also set if dep == 2;
  - for IMUL, bits 0 and 2 set in the EXT cycle.
- sim_end entry: retires normally, then go to HALT.
  - sim_done is set and remaining queued entries are discarded (no writes, no sb_clear).
  - wb_ready = 0 in HALT.
  - Only reset leaves HALT.
- Simultaneous push and pop: count is unchanged and ordering is preserved.
- Accepted opcodes 116/125 (conditional jumps) are retired with no write and no sb_clear bits.

## Timing
- Reset values:
  - regfile all 0; sb_clear 0; retire_valid 0; retired_pc 0; sim_done 0;
  - state RUN; queue empty; wb_ready 0 while reset is asserted, 1 from the first edge after release.
- Reset mid-operation: queue, FSM and the in-progress IMUL are abandoned immediately.
- Latency, from accepting edge N with an empty queue:
  - regfile updated and visible after edge N+1;
  - retire_valid and sb_clear high in cycle N+1;
  - IMUL completes at N+2.
- Throughput: 1 entry/cycle sustained; IMUL costs 2 cycles.
- Backpressure: with the queue full, wb_ready drops the cycle after the second push and rises the cycle after a pop.
- All outputs are registered; regfile writes happen on the posedge.

## Structure
- Shared package cpu_pkg:
  - EX_WB typedef;
  - opcode constants (OP_IMUL=247, OP_PUSH_LO=80, OP_PUSH_HI=87, OP_GRP1_81, OP_GRP1_83, OP_JE=116, OP_JNL=125);
  - REG_RAX=0, REG_RDX=2.
- Sub-module mod_retire_queue: 2-entry FIFO with push/pop/count/full/empty and a flush input used on HALT.

## Test plan
- mov imm: accept {opcode 199, rm 3, alu_result 0xDEAD} -> regfile[3]=0xDEAD one cycle later, sb_clear=0x1000 (bit 3, MSB-first), retire_valid=1.
- IMUL: {opcode 247, alu_result 0x6, alu_ext_result 0xFFFF_FFFF_FFFF_FFFF} -> regfile[0]=6 at N+1, regfile[2]=all-ones at N+2, single retire_valid pulse at N+2.
- Backpressure: push 3 back-to-back IMULs -> wb_ready low after 2 accepts; all three commit in order over 6 cycles, no entry lost.
- CMP/PUSH: {0x83, regByte 7, rm 1}, {opcode 82, rm 4} -> regfile unchanged; sb_clear bit 1, then bit 4.
- dep==2: {opcode 139, rm 5, regByte 6, dep 2} -> regfile[5] written, sb_clear bits 5 and 6 in the same cycle.
- sim_end: queue {sim_end=1, rm 1, 0x11}, {rm 2, 0x22} -> regfile[1]=0x11, regfile[2] untouched, sim_done=1 sticky, wb_ready=0; reset pulse low mid-IMUL -> all outputs at reset values.
